// File: rtl/gate_tt_pkg.sv
// Shared types for the gate truth-table sequencer: FSM state encoding and reference op codes.
package gate_tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

endpackage

// File: rtl/gate_tt_ref.sv
// Combinational reference function: reduction of the selected op over the gate input vector.
module gate_tt_ref
    import gate_tt_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  op_e             i_op,
    input  logic [N_IN-1:0] i_vec,
    output logic            o_exp
);

    always_comb begin
        o_exp = 1'b0;
        case (i_op)
            OP_AND:  o_exp = &i_vec;
            OP_OR:   o_exp = |i_vec;
            OP_XOR:  o_exp = ^i_vec;
            OP_NAND: o_exp = ~&i_vec;
            default: o_exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_tt_sequencer.sv
// Clocked truth-table sweep around a small gate: drives every input vector, samples and scores the output.
// Build option TT_STOP_ON_ERR_EN: end the sweep at the first mismatching vector.
//
// state  | meaning
// IDLE   | waiting for start after reset
// SETTLE | dut_in held, counting SETTLE_CYC cycles
// SAMPLE | compare dut_out with reference, advance or finish
// DONE   | results held, start restarts a sweep
module gate_tt_sequencer
    import gate_tt_pkg::*;
#(
    parameter int N_IN       = 2,
    parameter int SETTLE_CYC = 2,
    parameter int ERR_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op_sel,
    output logic [N_IN-1:0]  o_dut_in,
    input  logic             i_dut_out,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_cnt,
    output logic [N_IN-1:0]  o_fail_vec
);

    localparam int               CNT_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_e            r_state;
    op_e               r_op;
    logic [N_IN-1:0]   r_vec;
    logic [CNT_W-1:0]  r_cnt;
    logic [ERR_W-1:0]  r_err;
    logic [N_IN-1:0]   r_fail;

    state_e            w_state_nxt;
    op_e               w_op_nxt;
    logic [N_IN-1:0]   w_vec_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ERR_W-1:0]  w_err_nxt;
    logic [N_IN-1:0]   w_fail_nxt;
    logic              w_exp;
    logic              w_mismatch;

    gate_tt_ref #(
        .N_IN (N_IN)
    ) u_ref (
        .i_op  (r_op),
        .i_vec (r_vec),
        .o_exp (w_exp)
    );

    assign w_mismatch = (i_dut_out != w_exp);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_AND;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_err   <= '0;
            r_fail  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_vec   <= w_vec_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_vec_nxt   = r_vec;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_fail_nxt  = r_fail;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    w_state_nxt = ST_SETTLE;
                    w_op_nxt    = op_e'(i_op_sel);
                    w_vec_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = '0;
                    w_fail_nxt  = '0;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_SAMPLE: begin
                if (w_mismatch) begin
                    if (r_err != ERR_MAX) begin
                        w_err_nxt = r_err + ERR_W'(1);
                    end
                    // Only the first failing vector is kept for debug.
                    if (r_err == '0) begin
                        w_fail_nxt = r_vec;
                    end
                end
`ifdef TT_STOP_ON_ERR_EN
                if (w_mismatch || (r_vec == VEC_LAST)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_vec_nxt   = r_vec + N_IN'(1);
                    w_cnt_nxt   = '0;
                end
`else
                if (r_vec == VEC_LAST) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SETTLE;
                    w_vec_nxt   = r_vec + N_IN'(1);
                    w_cnt_nxt   = '0;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_dut_in   = r_vec;
    assign o_busy     = (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
    assign o_done     = (r_state == ST_DONE);
    assign o_pass     = (r_state == ST_DONE) && (r_err == '0);
    assign o_err_cnt  = r_err;
    assign o_fail_vec = r_fail;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: random sweeps against a truth-table model, scoreboard queue checked on done.
module tb_gate_tt_sequencer;

    localparam int N_IN  = 2;
    localparam int S0    = 2;
    localparam int SPAN  = S0 + 1;
    localparam int NVEC  = 4;
    localparam int S1    = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start0, start1;
    logic [1:0] op0, op1;
    logic [1:0] din0, din1;
    logic       dout0, dout1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [7:0] err0;
    logic [0:0] err1;
    logic [1:0] fvec0, fvec1;
    int         gmode0, gmode1;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int sweep_start = 0;
    bit active   = 1'b0;

    typedef struct {
        int err;
        int fvec;
        bit pass;
        int lat;
        int lastv;
    } exp_t;
    exp_t sb[$];

    // Truth table from the two input bits, A = bit0, B = bit1.
    function automatic logic ref_bit(int op, int v);
        int a;
        int b;
        a = v % 2;
        b = v / 2;
        case (op)
            0:       return (a * b) == 1;
            1:       return (a + b) > 0;
            2:       return ((a + b) % 2) == 1;
            default: return (a * b) == 0;
        endcase
    endfunction

    // Gate under test: 0-3 correct gates, 4 stuck-at-0, 5 stuck-at-1, 6 inverted AND.
    function automatic logic gate_f(int mode, int v);
        case (mode)
            0, 1, 2, 3: return ref_bit(mode, v);
            4:          return 1'b0;
            5:          return 1'b1;
            default:    return !ref_bit(0, v);
        endcase
    endfunction

    function automatic exp_t model(int op, int mode, int errmax, int span);
        exp_t e;
        e.err   = 0;
        e.fvec  = 0;
        e.lat   = NVEC * span;
        e.lastv = NVEC - 1;
        for (int v = 0; v < NVEC; v++) begin
            if (gate_f(mode, v) != ref_bit(op, v)) begin
                if (e.err == 0) e.fvec = v;
                if (e.err < errmax) e.err++;
`ifdef TT_STOP_ON_ERR_EN
                e.lat   = (v + 1) * span;
                e.lastv = v;
                break;
`endif
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    assign dout0 = gate_f(gmode0, int'(din0));
    assign dout1 = gate_f(gmode1, int'(din1));

    gate_tt_sequencer #(.N_IN(N_IN), .SETTLE_CYC(S0), .ERR_W(8)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_op_sel(op0),
        .o_dut_in(din0), .i_dut_out(dout0), .o_busy(busy0), .o_done(done0),
        .o_pass(pass0), .o_err_cnt(err0), .o_fail_vec(fvec0)
    );

    gate_tt_sequencer #(.N_IN(N_IN), .SETTLE_CYC(S1), .ERR_W(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_op_sel(op1),
        .o_dut_in(din1), .i_dut_out(dout1), .o_busy(busy1), .o_done(done1),
        .o_pass(pass1), .o_err_cnt(err1), .o_fail_vec(fvec1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    endtask

    // Monitor: follows dut_in during a sweep and scores each completed sweep.
    initial begin
        logic pd;
        exp_t e;
        pd = 1'b0;
        forever begin
            @(negedge clk);
            if (active && busy0) chk("dut_in_step", din0, (cyc - sweep_start) / SPAN);
            if (done0 && !pd) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL spurious_done: actual=1 required=0");
                end else begin
                    e = sb.pop_front();
                    chk("err_cnt", err0, e.err);
                    chk("fail_vec", fvec0, e.fvec);
                    chk("pass", pass0, e.pass);
                    chk("done_latency", cyc - sweep_start, e.lat);
                    chk("dut_in_held", din0, e.lastv);
                    chk("busy_at_done", busy0, 0);
                end
            end
            pd = done0;
        end
    end

    task automatic run_sweep(int op, int mode, bit pulse, bit chg);
        exp_t e;
        int   pk;
        bit   got;
        @(negedge clk);
        op0    = 2'(op);
        gmode0 = mode;
        e      = model(op, mode, 255, SPAN);
        sb.push_back(e);
        start0 = 1'b1;
        @(negedge clk);
        start0      = 1'b0;
        sweep_start = cyc;
        active      = 1'b1;
        chk("busy_after_start", busy0, 1);
        chk("done_clear_on_start", done0, 0);
        if (chg) op0 = 2'($urandom_range(3));
        pk  = pulse ? int'($urandom_range(1, e.lat - 1)) : -1;
        got = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            start0 = (k == pk);
            @(negedge clk);
            if (done0) got = 1'b1;
        end
        start0 = 1'b0;
        active = 1'b0;
        if (!got) begin
            chk("done_timeout", 0, 1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            sb.delete();
        end
    endtask

    initial begin
        bit got;
        int k1;
        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        op0    = 2'b00;
        op1    = 2'b00;
        gmode0 = 0;
        gmode1 = 0;
        repeat (3) @(negedge clk);
        chk("rst_dut_in", din0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_pass", pass0, 0);
        chk("rst_err_cnt", err0, 0);
        chk("rst_fail_vec", fvec0, 0);
        chk("rst_done1", done1, 0);
        rst_n = 1'b1;

        run_sweep(0, 0, 1'b0, 1'b0);
        run_sweep(0, 4, 1'b1, 1'b0);
        run_sweep(1, 0, 1'b0, 1'b1);
        run_sweep(0, 6, 1'b1, 1'b1);
        repeat (20) run_sweep($urandom_range(3), $urandom_range(6), 1'($urandom_range(1)), 1'($urandom_range(1)));

        // Reset in the middle of vector 10, after a mismatch has been recorded.
        @(negedge clk);
`ifdef TT_STOP_ON_ERR_EN
        op0 = 2'b11;
`else
        op0 = 2'b00;
`endif
        gmode0 = 5;
        start0 = 1'b1;
        @(negedge clk);
        start0      = 1'b0;
        sweep_start = cyc;
        active      = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (din0 == 2'b10) got = 1'b1;
        end
        chk("reach_vec10", got, 1);
        active = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_dut_in", din0, 0);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_pass", pass0, 0);
        chk("midrst_err_cnt", err0, 0);
        chk("midrst_fail_vec", fvec0, 0);
        repeat (20) @(negedge clk);
        chk("midrst_stays_idle", busy0 | done0, 0);

        // Narrow counter saturates, then a clean restart from DONE clears it.
        gmode1 = 6;
        op1    = 2'b00;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (done1) got = 1'b1;
        end
        chk("sat_done_seen", got, 1);
        chk("sat_err_cnt", err1, 1);
        chk("sat_fail_vec", fvec1, 0);
        chk("sat_pass", pass1, 0);
        gmode1 = 0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("restart_done_clear", done1, 0);
        chk("restart_err_clear", err1, 0);
        got = 1'b0;
        k1  = 0;
        for (int k = 1; k < 40 && !got; k++) begin
            @(negedge clk);
            if (done1) begin
                got = 1'b1;
                k1  = k;
            end
        end
        chk("restart_done_seen", got, 1);
        chk("restart_latency", k1, NVEC * (S1 + 1));
        chk("restart_err_cnt", err1, 0);
        chk("restart_pass", pass1, 1);
        chk("restart_fail_vec", fvec1, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
